// File: rtl/ps2_dir_decoder.sv
`timescale 1ns/1ps
// PS/2 keyboard front end: synchronise, glitch-filter, receive frames, decode movement/fire keys.
// Define PS2_PARITY_CHECK_EN to reject frames whose data+parity bits are not odd parity.
module ps2_dir_decoder #(
  parameter int TIMEOUT  = 2500,
  parameter int FILT_LEN = 4
) (
  input  logic       clk_25,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] Dir,
  output logic       fire,
  output logic       key_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(FILT_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_next;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [TW-1:0] tmo_cnt;
  logic          timeout, accept, stop_err, par_err;
  logic          ext, brk;
  logic          held_up, held_down, held_left, held_right, held_fire;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_bit;
`endif

  // The filtered clock only flips after FILT_LEN consecutive samples disagree with it.
  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      fall   <= 1'b0;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
        fall     <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    stop_err   = 1'b0;
    par_err    = 1'b0;
    timeout    = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT - 1));
    if (timeout) begin
      state_next = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!dat_s2) state_next = DATA;
        DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP: begin
          state_next = IDLE;
          if (!dat_s2) stop_err = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
          else if (!(^{shift, par_bit})) par_err = 1'b1;
`endif
          else accept = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Receive datapath; the timeout counter only runs while a frame is in flight.
  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= '0;
      shift     <= '0;
      tmo_cnt   <= '0;
      key_valid <= 1'b0;
      scan_code <= '0;
      frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      key_valid <= accept;
      frame_err <= stop_err | par_err | timeout;
      if (accept) scan_code <= shift;
      if (state == IDLE || fall) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
`ifdef PS2_PARITY_CHECK_EN
          PARITY: par_bit <= dat_s2;
`endif
          default: ;
        endcase
      end
    end
  end

  // Prefix bytes arm ext/brk; the next key byte consumes them.
  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      held_up    <= 1'b0;
      held_down  <= 1'b0;
      held_left  <= 1'b0;
      held_right <= 1'b0;
      held_fire  <= 1'b0;
    end else if (frame_err) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (key_valid) begin
      if (scan_code == 8'hE0) begin
        ext <= 1'b1;
      end else if (scan_code == 8'hF0) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        case ({ext, scan_code})
          9'h01D, 9'h175: held_up    <= !brk;
          9'h01B, 9'h172: held_down  <= !brk;
          9'h01C, 9'h16B: held_left  <= !brk;
          9'h023, 9'h174: held_right <= !brk;
          9'h029:         held_fire  <= !brk;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    Dir = 4'b0000;
    if      (held_up)    Dir = 4'b1000;
    else if (held_down)  Dir = 4'b0100;
    else if (held_left)  Dir = 4'b0010;
    else if (held_right) Dir = 4'b0001;
  end

  assign fire = held_fire;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
`timescale 1ns/1ps
// Self-checking bench for ps2_dir_decoder: directed vector table, multi-cycle corner cases
// and randomized frames checked against a key-set reference model.
module tb_ps2_dir_decoder;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clk_25 = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] Dir;
  logic       fire;
  logic       key_valid;
  logic [7:0] scan_code;
  logic       frame_err;

  ps2_dir_decoder dut (
    .clk_25(clk_25), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .Dir(Dir), .fire(fire), .key_valid(key_valid), .scan_code(scan_code),
    .frame_err(frame_err)
  );

  always #20 clk_25 = ~clk_25;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int kv_cyc = 0;
  int kv_count = 0;
  int fe_count = 0;
  int multi_hot = 0;
  logic [7:0] kv_code = 8'h00;
  logic [3:0] dir_at_kv = 4'b0000;
  logic [3:0] dir_after_kv = 4'b0000;
  logic       kv_prev = 1'b0;

  always @(posedge clk_25) cyc++;

  always @(negedge clk_25) begin
    if (kv_prev) dir_after_kv = Dir;
    kv_prev = key_valid;
    if (key_valid) begin
      kv_count++;
      kv_code   = scan_code;
      dir_at_kv = Dir;
      kv_cyc    = cyc;
    end
    if (frame_err) fe_count++;
    if (!$onehot0(Dir)) multi_hot++;
  end

  // Reference model: which of up/down/left/right/fire are held, plus pending prefixes.
  logic m_held[5];
  logic m_ext, m_brk;

  function automatic int keyIndex(input logic e, input logic [7:0] c);
    if (!e) begin
      case (c)
        8'h1D: return 0;
        8'h1B: return 1;
        8'h1C: return 2;
        8'h23: return 3;
        8'h29: return 4;
        default: return -1;
      endcase
    end else begin
      case (c)
        8'h75: return 0;
        8'h72: return 1;
        8'h6B: return 2;
        8'h74: return 3;
        default: return -1;
      endcase
    end
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 5; i++) m_held[i] = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic modelAccept(input logic [7:0] c);
    int idx;
    if (c == 8'hE0) m_ext = 1'b1;
    else if (c == 8'hF0) m_brk = 1'b1;
    else begin
      idx = keyIndex(m_ext, c);
      if (idx >= 0) m_held[idx] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  function automatic logic [3:0] modelDir();
    for (int i = 0; i < 4; i++)
      if (m_held[i]) return 4'b1000 >> i;
    return 4'b0000;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one PS/2 frame (first nbits of start, 8 data, parity, stop), device-side timing.
  task automatic applyStimulus(input logic [7:0] code, input int nbits,
                               input logic bad_par, input logic stop_val);
    logic [10:0] frame;
    frame = {stop_val, ~(^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      repeat (6) @(negedge clk_25);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (12) @(negedge clk_25);
      ps2_clk = 1'b1;
      repeat (6) @(negedge clk_25);
    end
    ps2_data = 1'b1;
  endtask

  task automatic doFrame(input logic [7:0] code, input logic stop_val, input logic bad_par);
    int kv0, fe0, lat;
    logic [3:0] dir0;
    logic acc;
    kv0  = kv_count;
    fe0  = fe_count;
    dir0 = modelDir();
    applyStimulus(code, 11, bad_par, stop_val);
    repeat (20) @(negedge clk_25);
    acc = stop_val && !(PCHK && bad_par);
    if (acc) modelAccept(code);
    else begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    checkOutput("key_valid_pulses", kv_count - kv0, acc ? 1 : 0);
    checkOutput("frame_err_pulses", fe_count - fe0, acc ? 0 : 1);
    if (acc) begin
      lat = kv_cyc - stop_cyc;
      checkOutput("scan_code", kv_code, code);
      checkOutput("kv_latency_in_window", (lat >= 1 && lat <= 11) ? 1 : 0, 1);
      checkOutput("dir_during_kv", dir_at_kv, dir0);
      checkOutput("dir_after_kv", dir_after_kv, modelDir());
    end
    checkOutput("Dir", Dir, modelDir());
    checkOutput("fire", fire, m_held[4]);
  endtask

  typedef struct {
    logic [7:0] code;
    logic [3:0] dir;
    logic       fire;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int kv0, fe0, r;
    logic [7:0] c;
    logic sv, bp;
    logic [7:0] pool[11];

    tbl[0]  = '{8'h1D, 4'b1000, 1'b0};
    tbl[1]  = '{8'hF0, 4'b1000, 1'b0};
    tbl[2]  = '{8'h1D, 4'b0000, 1'b0};
    tbl[3]  = '{8'hE0, 4'b0000, 1'b0};
    tbl[4]  = '{8'h6B, 4'b0010, 1'b0};
    tbl[5]  = '{8'h1D, 4'b1000, 1'b0};
    tbl[6]  = '{8'hF0, 4'b1000, 1'b0};
    tbl[7]  = '{8'h1D, 4'b0010, 1'b0};
    tbl[8]  = '{8'h29, 4'b0010, 1'b1};
    tbl[9]  = '{8'h29, 4'b0010, 1'b1};
    tbl[10] = '{8'hF0, 4'b0010, 1'b1};
    tbl[11] = '{8'h29, 4'b0010, 1'b0};
    tbl[12] = '{8'hE0, 4'b0010, 1'b0};
    tbl[13] = '{8'hF0, 4'b0010, 1'b0};
    tbl[14] = '{8'h6B, 4'b0000, 1'b0};
    pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29};
    modelReset();

    $display("[TB] reset with ps2_clk toggling");
    for (int i = 0; i < 24; i++) begin
      repeat (3) @(negedge clk_25);
      ps2_clk  = ~ps2_clk;
      ps2_data = 1'($urandom_range(0, 1));
      checkOutput("outputs_in_reset", {Dir, fire, key_valid, frame_err, scan_code}, 0);
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    @(negedge clk_25);
    reset = 1'b1;
    repeat (20) @(negedge clk_25);
    checkOutput("outputs_after_reset", {Dir, fire, key_valid, frame_err, scan_code}, 0);
    checkOutput("no_pulses_in_reset", kv_count + fe_count, 0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 15; i++) begin
      doFrame(tbl[i].code, 1'b1, 1'b0);
      checkOutput("table_dir", Dir, tbl[i].dir);
      checkOutput("table_fire", fire, tbl[i].fire);
    end

    $display("[TB] truncated frame timeout");
    kv0 = kv_count;
    fe0 = fe_count;
    applyStimulus(8'h00, 5, 1'b0, 1'b1);
    repeat (2600) @(negedge clk_25);
    m_ext = 1'b0;
    m_brk = 1'b0;
    checkOutput("timeout_frame_err", fe_count - fe0, 1);
    checkOutput("timeout_no_kv", kv_count - kv0, 0);
    doFrame(8'h23, 1'b1, 1'b0);
    checkOutput("after_timeout_dir", Dir, 4'b0001);
    doFrame(8'hF0, 1'b1, 1'b0);
    doFrame(8'h23, 1'b1, 1'b0);

    $display("[TB] even parity frame");
    doFrame(8'h1D, 1'b1, 1'b1);
    checkOutput("parity_dir", Dir, PCHK ? 4'b0000 : 4'b1000);
    doFrame(8'hF0, 1'b1, 1'b0);
    doFrame(8'h1D, 1'b1, 1'b0);

    $display("[TB] bad stop bit keeps held keys");
    doFrame(8'h1C, 1'b1, 1'b0);
    doFrame(8'hF0, 1'b0, 1'b0);
    doFrame(8'h1C, 1'b1, 1'b0);
    checkOutput("stop_err_dir", Dir, 4'b0010);

    $display("[TB] randomized frames");
    for (int n = 0; n < 50; n++) begin
      r  = $urandom_range(0, 12);
      c  = (r > 10) ? 8'($urandom) : pool[r];
      sv = ($urandom_range(0, 9) != 0);
      bp = ($urandom_range(0, 9) == 0);
      doFrame(c, sv, bp);
    end

    $display("[TB] reset mid-frame");
    kv0 = kv_count;
    fe0 = fe_count;
    ps2_data = 1'b0;
    repeat (6) @(negedge clk_25);
    ps2_clk = 1'b0;
    repeat (12) @(negedge clk_25);
    ps2_clk = 1'b1;
    applyStimulus(8'h1D, 5, 1'b0, 1'b1);
    reset = 1'b0;
    repeat (5) @(negedge clk_25);
    checkOutput("midframe_reset_outputs", {Dir, fire, key_valid, frame_err}, 0);
    reset = 1'b1;
    modelReset();
    repeat (2700) @(negedge clk_25);
    checkOutput("midframe_no_frame_err", fe_count - fe0, 0);
    checkOutput("midframe_no_kv", kv_count - kv0, 0);
    doFrame(8'h1C, 1'b1, 1'b0);
    checkOutput("recovery_dir", Dir, 4'b0010);

    checkOutput("dir_multi_hot_cycles", multi_hot, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_dir_decoder.md
Name: ps2_dir_decoder

Overview:
- Upstream input stage for the airplane game core.
- Receives PS/2 keyboard scan codes, tracks which movement and fire keys are held, and drives the one-hot `Dir[3:0]` bus plus a fire level consumed by the airplane/game logic.
- Runs in the 25 MHz pixel clock domain; asynchronous PS/2 lines are synchronised internally.

Parameters:
- TIMEOUT, 2500, clk_25 cycles without a PS/2 falling edge mid-frame before the frame is aborted (100 us).
- FILT_LEN, 4, consecutive identical synchronised samples required before ps2_clk is accepted as changed (glitch filter).

Ports:
- clk_25  input  1  system clock, 25 MHz
- reset  input  1  asynchronous, active-low reset (0 = reset)
- ps2_clk  input  1  raw PS/2 clock from the connector
- ps2_data  input  1  raw PS/2 data from the connector
- Dir  output  4  one-hot movement: 1000 up, 0100 down, 0010 left, 0001 right, 0000 none
- fire  output  1  high while the fire key is held
- key_valid  output  1  one-cycle pulse per accepted scan byte
- scan_code  output  8  last accepted byte, valid when key_valid is high
- frame_err  output  1  one-cycle pulse on a framing, timeout or (optional) parity error

Behaviour:
- Reset (reset=0, asynchronous): Dir=0000, fire=0, key_valid=0, scan_code=8'h00, frame_err=0, all held-key flags clear, prefix flags clear, FSM in IDLE.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - ps2_clk is additionally filtered by FILT_LEN.
  - A falling edge of the filtered clock produces a one-cycle `fall` strobe; ps2_data is sampled on that strobe.
- Receive FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 (start bit), clear the bit counter and go to DATA. On `fall` with data=1, stay in IDLE; no error.
  - DATA: shift data in LSB first, 8 bits; after the 8th `fall` go to PARITY.
  - PARITY: capture the parity bit; go to STOP.
  - STOP: on `fall`:
    - data=1: the byte is accepted.
    - data=0: frame_err pulses and the byte is discarded.
    - Either way, return to IDLE.
  - Timeout: in any state other than IDLE, a counter reloads on each `fall`. Reaching TIMEOUT forces IDLE and pulses frame_err; the partial byte is discarded.
- Acceptance timing: key_valid and scan_code are asserted the cycle after the stop-bit `fall`. Dir and fire update one cycle after key_valid (latency 2 cycles from the stop-bit `fall`).
- Scan-code decode:
  - 8'hE0 sets the ext flag.
  - 8'hF0 sets the brk flag.
  - Any other byte is a key event. It sets (brk=0) or clears (brk=1) the matching held flag, then both ext and brk clear.
  - Key map:
    - up = 1D or E0 75
    - down = 1B or E0 72
    - left = 1C or E0 6B
    - right = 23 or E0 74
    - fire = 29
  - Unmapped codes are accepted (key_valid pulses) but change no held flag.
- Dir is a fixed-priority encoding of the held flags: up > down > left > right. It is never multi-hot.
- `fire` equals the fire held flag.
- A repeated make code (typematic) for an already-held key leaves the outputs unchanged.
- A frame error or timeout clears the ext and brk flags but keeps the held flags.
- Reset asserted mid-frame aborts the frame immediately; no key_valid or frame_err pulse is produced.

Optional Feature:
- PS2_PARITY_CHECK_EN defined: an accepted frame whose 9 bits (data plus parity) are not odd parity is discarded at STOP. frame_err pulses, key_valid stays 0, and held flags are unchanged.
- PS2_PARITY_CHECK_EN undefined: the parity bit is captured and ignored; only start, stop and timeout are checked.

Test Plan:
- Reset while ps2_clk toggles -> Dir=0000, fire=0, key_valid=0, frame_err=0 during and after reset.
- Send frame 1D (make W) -> key_valid pulses once with scan_code=8'h1D; Dir=1000 two cycles after the stop-bit `fall`. Then send F0,1D -> Dir=0000.
- Send E0 6B (left held), then 1D (up) -> Dir goes 0010 then 1000. Send F0 1D -> Dir returns to 0010.
- Send 29 -> fire=1. Send 29 again (typematic) -> fire stays 1. Send F0 29 -> fire=0.
- Send start plus 4 data bits, then idle 2600 cycles -> frame_err pulses once; FSM in IDLE; next full frame 23 -> Dir=0001.
- With PS2_PARITY_CHECK_EN, send 1D with even parity -> frame_err=1, no key_valid, Dir stays 0000. Without the macro -> Dir=1000.
